store_write_buffer: RTL
=======================

# store_write_buffer

Receiving end of the store reservation station's write-buffer interface. Captures each resolved store (ROB position, effective address, store value) into an in-order circular buffer. Holds the store until the reorder buffer commits that position, then drains committed stores to data memory over a valid/ready handshake. Discards uncommitted stores on a pipeline flush.

## Interface
- REORDER_BUFFER_SIZE_LOG, 4, width of ROB position tags
- DEPTH_LOG, 2, log2 of buffer entries (DEPTH = 4)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clears all state
- writeBuffer_valid  in  1  store RS presents a resolved store this cycle
- writeBuffer_position  in  REORDER_BUFFER_SIZE_LOG  ROB position of the store
- writeBuffer_value  in  32  effective address
- writeBuffer_storeValue  in  32  data to store
- full  out  1  all DEPTH entries occupied; store RS must hold
- commit_valid  in  1  ROB commits a store this cycle
- commit_position  in  REORDER_BUFFER_SIZE_LOG  ROB position being committed
- commit_miss  out  1  registered 1-cycle pulse: commit matched no uncommitted entry
- flush  in  1  discard all uncommitted entries
- mem_write_valid  out  1  write request to data memory
- mem_write_address  out  32  address of head entry
- mem_write_data  out  32  data of head entry
- mem_write_ready  in  1  memory accepts the request
- empty  out  1  no entries held
- count  out  DEPTH_LOG+1  number of occupied entries

## Operation
- Entry fields: valid, committed, position, address, data. Head and tail pointers are DEPTH_LOG bits and wrap modulo DEPTH. The store RS delivers stores in program order, so buffer order is program order.
- Enqueue: on writeBuffer_valid && !full && !flush, write the entry at tail with committed=0, then tail+1.
  - Enqueue while full is dropped; count is unchanged.
- Commit: on commit_valid, set committed=1 on the valid, uncommitted entry whose position equals commit_position.
  - If no entry matches, nothing changes and commit_miss pulses on the next cycle.
  - Committed entries always form a prefix starting at head.
- Drain FSM, two states:
  - IDLE: if the head entry is valid and committed, go to WRITE.
  - WRITE: mem_write_valid=1; address and data come from the head entry and are stable while in WRITE.
  - On mem_write_ready in WRITE: invalidate head, head+1. Stay in WRITE if the next entry is valid and committed; otherwise go to IDLE.
- Flush: invalidate every uncommitted entry and set tail to head + (number of committed entries).
  - Committed entries and an in-progress WRITE are unaffected.
- Simultaneous events:
  - Commit and flush in the same cycle: commit is applied first, so the committed entry survives.
  - Enqueue and flush in the same cycle: the enqueue is dropped.
  - Enqueue and dequeue in the same cycle: count is unchanged.
  - full and empty are computed from registered count. A store arriving in the cycle the last slot frees while full is still dropped.
  - A commit for a store being enqueued in the same cycle is a miss; the ROB never does this.
- count = enqueues - dequeues - flushed entries, in the range 0..DEPTH.
- Reset: all entries invalid, head=tail=0, FSM in IDLE.

## Timing
- Reset values: full=0, commit_miss=0, mem_write_valid=0, mem_write_address=0, mem_write_data=0, empty=1, count=0.
- An enqueued entry is visible (count, empty, commit match) from the cycle after writeBuffer_valid.
- Commit at cycle N on a committed-eligible head: mem_write_valid rises at N+1.
- Throughput: one memory write per cycle while mem_write_ready stays high and committed entries remain.
- mem_write_valid, once high, is never withdrawn until mem_write_ready, including across a flush.
- Reset asserted mid-WRITE: mem_write_valid=0 on the next cycle; the pending write is abandoned.

## Test plan
- Basic path:
  - Stimulus: enqueue (pos 0, addr 12, data 5); commit pos 0 two cycles later; mem_write_ready=1.
  - Response: mem_write_valid=1 with address 12, data 5 exactly one cycle after the commit; then empty=1, count=0.
- Fill and stall:
  - Stimulus: enqueue pos 0..4 on consecutive cycles with no commits.
  - Response: full=1 after the fourth; the pos 4 store is dropped; count=4. Commit pos 0..4 in order: writes for pos 0..3 only, and pos 4 gives a commit_miss pulse.
- Memory backpressure:
  - Stimulus: two committed stores (addr 12/data 5, addr 16/data 7); mem_write_ready low for 3 cycles, then high.
  - Response: address 12 / data 5 held stable for 4 cycles; then address 16 / data 7 on the following cycle.
- Flush:
  - Stimulus: enqueue pos 1,2,3; commit pos 1 and flush in the same cycle.
  - Response: only the pos 1 write (addr/data as enqueued) reaches memory; count goes to 1, then 0; the next enqueue lands at tail = head+1.
- Wrap-around:
  - Stimulus: stream 10 stores with immediate commits and ready held high.
  - Response: all 10 writes appear in order with correct address/data; pointers wrap, count never exceeds 4.
- Reset mid-write:
  - Stimulus: assert reset while mem_write_valid=1.
  - Response: every output at its reset value next cycle, empty=1.

Source files
------------

// File: rtl/store_write_buffer.sv
// store_write_buffer
// In-order circular buffer between the store reservation station and data
// memory. Stores are captured when resolved, held until the reorder buffer
// commits them, then drained to memory in program order over valid/ready.
// A flush discards every store that has not yet been committed.

module store_write_buffer #(
    parameter int REORDER_BUFFER_SIZE_LOG = 4,
    parameter int DEPTH_LOG               = 2
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic                               writeBuffer_valid,
    input  logic [REORDER_BUFFER_SIZE_LOG-1:0] writeBuffer_position,
    input  logic [31:0]                        writeBuffer_value,
    input  logic [31:0]                        writeBuffer_storeValue,
    output logic                               full,

    input  logic                               commit_valid,
    input  logic [REORDER_BUFFER_SIZE_LOG-1:0] commit_position,
    output logic                               commit_miss,

    input  logic                               flush,

    output logic                               mem_write_valid,
    output logic [31:0]                        mem_write_address,
    output logic [31:0]                        mem_write_data,
    input  logic                               mem_write_ready,

    output logic                               empty,
    output logic [DEPTH_LOG:0]                 count
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_COUNT = (DEPTH_LOG + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        WRITE
    } drain_state_t;

    // Entry storage
    logic [DEPTH-1:0]                   entry_valid;
    logic [DEPTH-1:0]                   entry_committed;
    logic [REORDER_BUFFER_SIZE_LOG-1:0] entry_position [DEPTH];
    logic [31:0]                        entry_address  [DEPTH];
    logic [31:0]                        entry_data     [DEPTH];

    // Pointers, occupancy and control state
    logic [DEPTH_LOG-1:0] head;
    logic [DEPTH_LOG-1:0] tail;
    logic [DEPTH_LOG-1:0] head_plus_one;
    logic [DEPTH_LOG:0]   count_q;
    logic [DEPTH_LOG:0]   count_next;
    drain_state_t         state;
    drain_state_t         state_next;
    logic                 commit_miss_q;

    // Per-cycle decisions
    logic                 enqueue;
    logic                 dequeue;
    logic                 commit_hit;
    logic [DEPTH_LOG-1:0] commit_index;
    logic [DEPTH-1:0]     committed_eff;
    logic [DEPTH_LOG:0]   committed_count;
    logic                 head_ready;
    logic                 next_ready;

    assign full          = (count_q == DEPTH_COUNT);
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign commit_miss   = commit_miss_q;
    assign head_plus_one = head + DEPTH_LOG'(1);
    assign enqueue       = writeBuffer_valid && !full && !flush;
    assign dequeue       = (state == WRITE) && mem_write_ready;

    // Locate the uncommitted entry named by the ROB commit, if any
    always_comb begin
        commit_hit   = 1'b0;
        commit_index = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid && !commit_hit && entry_valid[i] &&
                !entry_committed[i] &&
                (entry_position[i] == commit_position)) begin
                commit_hit   = 1'b1;
                commit_index = DEPTH_LOG'(i);
            end
        end
    end

    // Committed view including this cycle's commit, so a flush in the same
    // cycle keeps the entry and the drain can start without an extra cycle
    always_comb begin
        committed_eff   = '0;
        committed_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            committed_eff[i] = entry_committed[i] ||
                               (commit_hit && (commit_index == DEPTH_LOG'(i)));
            committed_count  = committed_count +
                               (DEPTH_LOG + 1)'(entry_valid[i] && committed_eff[i]);
        end
    end

    // Readiness of the head entry and the one behind it for draining
    always_comb begin
        head_ready = entry_valid[head] && committed_eff[head];
        next_ready = entry_valid[head_plus_one] && committed_eff[head_plus_one];
    end

    // Next occupancy; a flush keeps only committed entries, minus any that
    // leave for memory in the same cycle
    always_comb begin
        count_next = count_q;
        if (flush) begin
            count_next = committed_count - (DEPTH_LOG + 1)'(dequeue);
        end else begin
            count_next = count_q + (DEPTH_LOG + 1)'(enqueue)
                                 - (DEPTH_LOG + 1)'(dequeue);
        end
    end

    // Drain FSM next-state: start on a committed head, keep streaming while
    // the following entry is committed as well
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (head_ready) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (mem_write_ready) begin
                    state_next = next_ready ? WRITE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory request outputs; payload is held at zero outside a write
    always_comb begin
        mem_write_valid   = 1'b0;
        mem_write_address = '0;
        mem_write_data    = '0;
        if (state == WRITE) begin
            mem_write_valid   = 1'b1;
            mem_write_address = entry_address[head];
            mem_write_data    = entry_data[head];
        end
    end

    // Entry flags: commit marking, flush discard, dequeue and enqueue
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_valid     <= '0;
            entry_committed <= '0;
        end else begin
            if (commit_hit) begin
                entry_committed[commit_index] <= 1'b1;
            end
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!committed_eff[i]) begin
                        entry_valid[i] <= 1'b0;
                    end
                end
            end
            if (dequeue) begin
                entry_valid[head]     <= 1'b0;
                entry_committed[head] <= 1'b0;
            end
            if (enqueue) begin
                entry_valid[tail]     <= 1'b1;
                entry_committed[tail] <= 1'b0;
            end
        end
    end

    // Entry payload written at the tail on enqueue
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_position[i] <= '0;
                entry_address[i]  <= '0;
                entry_data[i]     <= '0;
            end
        end else if (enqueue) begin
            entry_position[tail] <= writeBuffer_position;
            entry_address[tail]  <= writeBuffer_value;
            entry_data[tail]     <= writeBuffer_storeValue;
        end
    end

    // Pointers, occupancy, drain state and the commit-miss pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count_q       <= '0;
            state         <= IDLE;
            commit_miss_q <= 1'b0;
        end else begin
            state         <= state_next;
            count_q       <= count_next;
            commit_miss_q <= commit_valid && !commit_hit;
            if (dequeue) begin
                head <= head_plus_one;
            end
            if (flush) begin
                tail <= head + committed_count[DEPTH_LOG-1:0];
            end else if (enqueue) begin
                tail <= tail + DEPTH_LOG'(1);
            end
        end
    end

endmodule
